// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline-stage register with 2-entry skid, flush and bubble counter
//
// One instance sits between two pipeline stages. It holds a main entry, which
// drives the outputs, and a skid entry, which absorbs one extra beat when the
// downstream stage stalls. Together they keep full throughput while IN_READY
// stays a registered signal.
//
// Parameters:
//   CTRL_W     width of the control bundle (zeroed on reset and flush)
//   DATA_W     width of the data bundle
//   FLUSH_DATA 1 = data bundle also zeroed on flush, 0 = data held on flush
//   CNT_W      width of the saturating bubble counter (>= 2)
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   IN_VALID/IN_READY     upstream handshake (IN_READY = skid empty, registered)
//   IN_CTRL, IN_DATA      upstream bundles
//   FLUSH                 drop all held entries and any entry offered this cycle
//   OUT_VALID/OUT_READY   downstream handshake
//   OUT_CTRL, OUT_DATA    main-entry bundles (OUT_CTRL forced to 0 when invalid)
//   BUBBLE_CNT            cycles with OUT_VALID=0 since reset, saturating

module pipe_stage_reg #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 112,
    parameter int FLUSH_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CNT_W-1:0]  BUBBLE_CNT
);

    logic              m_v_q, m_v_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_v_q, s_v_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic acc;
    logic drn;

    assign IN_READY   = ~s_v_q;
    assign OUT_VALID  = m_v_q;
    assign OUT_CTRL   = m_v_q ? m_ctrl_q : '0;
    assign OUT_DATA   = m_data_q;
    assign BUBBLE_CNT = bubble_cnt_q;

    assign acc = IN_VALID & ~s_v_q;
    assign drn = m_v_q & OUT_READY;

    always_comb begin
        m_v_d    = m_v_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_v_d    = s_v_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        if (FLUSH) begin
            // A drain this cycle has already completed downstream; everything
            // still held, and anything offered, becomes a bubble.
            m_v_d    = 1'b0;
            s_v_d    = 1'b0;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (FLUSH_DATA != 0) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (drn) begin
            if (s_v_q) begin
                // acc cannot occur here because IN_READY is low while skid is full.
                m_v_d    = 1'b1;
                m_ctrl_d = s_ctrl_q;
                m_data_d = s_data_q;
                s_v_d    = 1'b0;
            end else if (acc) begin
                m_v_d    = 1'b1;
                m_ctrl_d = IN_CTRL;
                m_data_d = IN_DATA;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (acc) begin
            if (m_v_q) begin
                s_v_d    = 1'b1;
                s_ctrl_d = IN_CTRL;
                s_data_d = IN_DATA;
            end else begin
                m_v_d    = 1'b1;
                m_ctrl_d = IN_CTRL;
                m_data_d = IN_DATA;
            end
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!m_v_q && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_v_q        <= 1'b0;
            m_ctrl_q     <= '0;
            m_data_q     <= '0;
            s_v_q        <= 1'b0;
            s_ctrl_q     <= '0;
            s_data_q     <= '0;
            bubble_cnt_q <= '0;
        end else begin
            m_v_q        <= m_v_d;
            m_ctrl_q     <= m_ctrl_d;
            m_data_q     <= m_data_d;
            s_v_q        <= s_v_d;
            s_ctrl_q     <= s_ctrl_d;
            s_data_q     <= s_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 112;

    logic              CLK = 1'b0;
    logic              RST;
    logic              IN_VALID;
    logic [CTRL_W-1:0] IN_CTRL;
    logic [DATA_W-1:0] IN_DATA;
    logic              FLUSH;
    logic              OUT_READY;

    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       bubble_cnt;

    logic              sm_in_ready, sm_out_valid;
    logic [CTRL_W-1:0] sm_out_ctrl;
    logic [DATA_W-1:0] sm_out_data;
    logic [1:0]        sm_bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t sb_q[$];

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_DATA(1), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA), .FLUSH(FLUSH),
        .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .OUT_CTRL(out_ctrl),
        .OUT_DATA(out_data), .BUBBLE_CNT(bubble_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_DATA(0), .CNT_W(2)) dut_sm (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(sm_in_ready),
        .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA), .FLUSH(FLUSH),
        .OUT_VALID(sm_out_valid), .OUT_READY(OUT_READY), .OUT_CTRL(sm_out_ctrl),
        .OUT_DATA(sm_out_data), .BUBBLE_CNT(sm_bubble_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: sampled mid-cycle, i.e. the values the next edge will see.
    always @(negedge CLK) begin
        if (RST) begin
            sb_q.delete();
        end else begin
            if (!out_valid) check("ctrl_zero_when_invalid", out_ctrl, 0);
            if (out_valid && OUT_READY) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", out_ctrl, 0);
                    if (out_ctrl == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_output got=output exp=none");
                    end
                end else begin
                    entry_t e;
                    e = sb_q.pop_front();
                    check("sb_ctrl", out_ctrl, e.ctrl);
                    check("sb_data", out_data, e.data);
                end
            end
            if (FLUSH) sb_q.delete();
            else if (IN_VALID && in_ready) sb_q.push_back('{ctrl: IN_CTRL, data: IN_DATA});
        end
    end

    task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        IN_VALID = 1'b1;
        IN_CTRL  = c;
        IN_DATA  = d;
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_CTRL = 16'hFFFF; IN_DATA = '1;

        // Reset / idle
        tick(); tick();
        RST = 1'b0; IN_VALID = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_bubble", bubble_cnt, 0);
        tick(); tick(); tick();
        check("idle_bubble3", bubble_cnt, 3);

        // Streaming, one per cycle
        OUT_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i[CTRL_W-1:0], DATA_W'(100 + i - 1));
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_ctrl", out_ctrl, i);
            check("stream_data", out_data, 100 + i - 1);
            check("stream_in_ready", in_ready, 1);
        end
        IN_VALID = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);

        // Back-pressure
        OUT_READY = 1'b0;
        offer(16'hA, 112'hAAA); tick();
        check("bp_main_a", out_ctrl, 16'hA);
        check("bp_ready_a", in_ready, 1);
        offer(16'hB, 112'hBBB); tick();
        check("bp_ready_b", in_ready, 0);
        offer(16'hC, 112'hCCC); tick();
        check("bp_hold_a", out_ctrl, 16'hA);
        check("bp_hold_ready", in_ready, 0);
        OUT_READY = 1'b1; tick();
        check("bp_out_b", out_ctrl, 16'hB);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_out_c", out_ctrl, 16'hC);
        check("bp_out_c_data", out_data, 112'hCCC);
        IN_VALID = 1'b0; tick();
        check("bp_empty", out_valid, 0);

        // Flush with full skid
        OUT_READY = 1'b0;
        offer(16'h1A, 112'h1A1A); tick();
        offer(16'h1B, 112'h1B1B); tick();
        check("fl_skid_full", in_ready, 0);
        offer(16'h1C, 112'h1C1C); FLUSH = 1'b1; tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_out_data", out_data, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_keep_data", sm_out_data, 112'h1A1A);
        check("fl_sm_ctrl", sm_out_ctrl, 0);
        OUT_READY = 1'b1;
        tick(); tick();
        check("fl_c_gone", out_valid, 0);

        // Flush and reset together
        OUT_READY = 1'b0;
        offer(16'h2A, 112'h2A2A); tick();
        offer(16'h2B, 112'h2B2B); tick();
        IN_VALID = 1'b0; RST = 1'b1; FLUSH = 1'b1; tick();
        RST = 1'b0; FLUSH = 1'b0;
        check("fr_out_valid", out_valid, 0);
        check("fr_out_ctrl", out_ctrl, 0);
        check("fr_out_data", out_data, 0);
        check("fr_in_ready", in_ready, 1);
        check("fr_bubble", bubble_cnt, 0);
        check("fr_sm_data", sm_out_data, 0);
        check("fr_sm_bubble", sm_bubble_cnt, 0);

        // Counter saturation on the CNT_W=2 instance
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("sat_sm_bubble", sm_bubble_cnt, (i < 3) ? i : 3);
            check("sat_bubble", bubble_cnt, i);
        end

        @(negedge CLK);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register. It is the successor to the fixed-field, always-loading stage latches between IF/ID/EX/MEM/WB. It carries one control bundle and one data bundle per instruction, with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush that turns held instructions into harmless bubbles. It also provides a saturating bubble counter for performance measurement. One instance sits at each pipeline boundary; the fields are packed by the instantiating stage.

Parameters:
CTRL_W, 16, width of the control bundle (ALUOp, mem enables, RF_WE, ...); zeroed on flush and reset.
DATA_W, 112, width of the data bundle (IMM, RD1, RD2, register addresses, PC, ...).
FLUSH_DATA, 0, 1 = the data bundle is also zeroed on flush; 0 = data is left unchanged on flush.
CNT_W, 16, width of the bubble counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous reset, active-high.
IN_VALID  input  1  upstream entry valid.
IN_READY  output  1  stage can accept an entry; registered, equals "skid entry empty".
IN_CTRL  input  CTRL_W  upstream control bundle.
IN_DATA  input  DATA_W  upstream data bundle.
FLUSH  input  1  discard all held entries and any entry offered this cycle.
OUT_VALID  output  1  main entry valid.
OUT_READY  input  1  downstream accepts the main entry.
OUT_CTRL  output  CTRL_W  main-entry control bundle; all zeros whenever OUT_VALID=0.
OUT_DATA  output  DATA_W  main-entry data bundle.
BUBBLE_CNT  output  CNT_W  count of cycles with OUT_VALID=0 since reset; saturates.

Behaviour:
- State: main entry {m_v, m_ctrl, m_data} drives the outputs; skid entry {s_v, s_ctrl, s_data}.
- Reset (RST=1 at a rising edge): m_v=s_v=0; m_ctrl=s_ctrl=0; m_data=s_data=0; BUBBLE_CNT=0. Resulting outputs: OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=1. RST has priority over FLUSH and over both handshakes.
- The accept event is acc = IN_VALID & IN_READY. The drain event is drn = OUT_VALID & OUT_READY.
- IN_READY = ~s_v. It is registered and has no combinational path from OUT_READY.
- Latency: an entry accepted at edge k appears on OUT_* after edge k (1 cycle) when the main entry is empty or draining.
- Throughput: with OUT_READY held at 1, the stage sustains one entry per cycle.
- Update rules when FLUSH=0:
  - acc, m_v=0 (or drn), s_v=0 -> the entry loads into main.
  - acc, m_v=1, no drn -> the entry loads into skid; IN_READY=0 from the next cycle.
  - drn, s_v=1 -> skid moves to main; s_v=0; IN_READY=1 from the next cycle.
  - drn, s_v=0, no acc -> m_v=0.
  - Neither event -> hold all state.
- Ordering: strictly FIFO. The skid entry is never emitted before the main entry.
- OUT_CTRL = m_v ? m_ctrl : 0. An invalid slot never presents nonzero control.
- Flush (FLUSH=1, RST=0):
  - Next state: m_v=s_v=0, m_ctrl=s_ctrl=0.
  - If FLUSH_DATA=1, m_data=s_data=0; otherwise data holds.
  - An entry offered that cycle is dropped, even though IN_READY may be 1.
  - A drain occurring in the same cycle still counts as completed downstream.
- Flush while the skid is full: both entries are discarded and IN_READY=1 on the next cycle.
- BUBBLE_CNT increments by 1 at each edge where OUT_VALID=0 (pre-edge value) and RST=0. It holds at 2^CNT_W-1; it does not wrap.
- Zero-width parameters are not supported. CTRL_W and DATA_W must be >= 1; CNT_W must be >= 2.

Test Plan:
- Reset/idle: assert RST 2 cycles with IN_VALID=1 and IN_CTRL=16'hFFFF -> OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=1, BUBBLE_CNT=0 after release; BUBBLE_CNT=3 three idle cycles later.
- Streaming: OUT_READY=1; send ctrl 1..8, data 100..107 back-to-back -> each appears exactly 1 cycle after acceptance, in order, with no gaps; IN_READY stays 1.
- Back-pressure: send A, B, C with OUT_READY=0 -> A in main, B in skid, IN_READY=0 and C held upstream; raise OUT_READY -> A, B, C emerge on consecutive cycles and IN_READY returns to 1 after B moves to main.
- Flush with full skid: main=A, skid=B, IN_VALID=1 with C, pulse FLUSH 1 cycle -> next cycle OUT_VALID=0, OUT_CTRL=0, IN_READY=1; C never emerges; with FLUSH_DATA=1, OUT_DATA=0.
- Flush vs reset priority: FLUSH=1 and RST=1 together while holding entries -> state identical to plain reset, including BUBBLE_CNT=0.
- Counter saturation: CNT_W=2, hold idle 6 cycles -> BUBBLE_CNT goes 1, 2, 3, 3, 3, 3.
